store_buffer: RTL and testbench

- Posted-write FIFO between the M-stage pipeline register and the data memory.
- Stores retire from the pipeline in one cycle and are queued here.
- The buffer drains one store per cycle into the single DM port whenever no load needs that port.
- Loads that hit a pending store's word raise a hazard so the pipeline stalls until that store has drained, keeping memory ordering exact.

---
 rtl/store_buffer.sv | 124 ++++++++++++
 tb/tb_store_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer sitting between the M-stage pipeline register and
// the single-ported data memory. Stores are queued in FIFO order and drained
// one per cycle whenever a load is not using the DM port. A load that hits
// the word of a pending store raises ld_hazard so the pipeline stalls until
// that store has reached memory.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_wd,
    input  logic [1:0]               st_width,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic                     dm_we,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wd,
    output logic [1:0]               dm_width,
    output logic [31:0]              dm_pc,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] WidthWord    = 2'b00;
    localparam logic [1:0] WidthInvalid = 2'b11;

    // Entry storage; only pointers and count carry reset state.
    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] wd_mem    [DEPTH];
    logic [1:0]  width_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          word_hit;
    logic [PW-1:0] offset;
    logic          full;
    logic          drain;
    logic          push;

    // Word-granular match of the load against every pending entry.
    always_comb begin
        word_hit = 1'b0;
        offset   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Entry i is pending when its distance from head is below count.
            offset = PW'(i) - head_q;
            if (({1'b0, offset} < count_q) &&
                (addr_mem[i][AW+1:2] == ld_addr[AW+1:2])) begin
                word_hit = 1'b1;
            end
        end
    end

    // Port arbitration: a non-stalled load owns the DM port, otherwise drain.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        ld_hazard = ld_valid && word_hit;
        drain     = !empty && (!ld_valid || ld_hazard);
        // At full, a push is still taken when the head drains on the same edge.
        st_ready  = !full || drain;
        push      = st_valid && st_ready && (st_width != WidthInvalid);
        count     = count_q;
    end

    // DM port mux: head entry while draining, otherwise the load address.
    always_comb begin
        dm_we    = drain;
        dm_addr  = ld_addr;
        dm_wd    = '0;
        dm_width = WidthWord;
        dm_pc    = '0;
        if (drain) begin
            dm_addr  = addr_mem[head_q];
            dm_wd    = wd_mem[head_q];
            dm_width = width_mem[head_q];
            dm_pc    = pc_mem[head_q];
        end
    end

    // Head/tail pointers and occupancy, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (drain) begin
                head_q <= head_q + PW'(1);
            end
            unique case ({push, drain})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry write at tail on an accepted, valid-width store.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_mem[tail_q]  <= st_addr;
            wd_mem[tail_q]    <= st_wd;
            width_mem[tail_q] <= st_width;
            pc_mem[tail_q]    <= st_pc;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: table of per-cycle vectors plus hand-written
// sequences, with a scoreboard queue of expected DM writes.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wd;
    logic [1:0]  st_width;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [1:0]  dm_width;
    logic [31:0] dm_pc;
    logic        empty;
    logic [2:0]  count;

    store_buffer #(.DEPTH(4), .AW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_wd     (st_wd),
        .st_width  (st_width),
        .st_pc     (st_pc),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wd     (dm_wd),
        .dm_width  (dm_width),
        .dm_pc     (dm_pc),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st_valid;
        logic [31:0] st_addr;
        logic [31:0] st_wd;
        logic [1:0]  st_width;
        logic        ld_valid;
        logic [31:0] ld_addr;
        logic        exp_ready;
        logic        exp_haz;
        logic        exp_we;
        logic [2:0]  exp_count;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  width;
        logic [31:0] pc;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [31:0] FarLd = 32'h200;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic sv, input logic [31:0] sa, input logic [31:0] swd,
                       input logic [1:0] sw, input logic lv, input logic [31:0] la,
                       input logic er, input logic eh, input logic ew, input logic [2:0] ec);
        vec_t v;
        v.st_valid = sv; v.st_addr = sa; v.st_wd = swd; v.st_width = sw;
        v.ld_valid = lv; v.ld_addr = la;
        v.exp_ready = er; v.exp_haz = eh; v.exp_we = ew; v.exp_count = ec;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        wr_t e;
        e.addr = a; e.wd = d; e.width = w; e.pc = 32'h1000 + a;
        sb.push_back(e);
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] swd,
                         input logic [1:0] sw, input logic lv, input logic [31:0] la);
        st_valid = sv; st_addr = sa; st_wd = swd; st_width = sw;
        st_pc = 32'h1000 + sa; ld_valid = lv; ld_addr = la;
    endtask

    // Compare any DM write seen this cycle against the oldest expected store.
    task automatic sample_dm();
        wr_t e;
        if (dm_we === 1'b1) begin
            check("dm_we_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("dm_addr", dm_addr, e.addr);
                check("dm_wd", dm_wd, e.wd);
                check("dm_width", 32'(dm_width), 32'(e.width));
                check("dm_pc", dm_pc, e.pc);
            end
        end
    endtask

    task automatic finish_cycle();
        sample_dm();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.st_valid, v.st_addr, v.st_wd, v.st_width, v.ld_valid, v.ld_addr);
        #4;
        check($sformatf("v%0d_st_ready", idx), 32'(st_ready), 32'(v.exp_ready));
        check($sformatf("v%0d_ld_hazard", idx), 32'(ld_hazard), 32'(v.exp_haz));
        check($sformatf("v%0d_dm_we", idx), 32'(dm_we), 32'(v.exp_we));
        check($sformatf("v%0d_count", idx), 32'(count), 32'(v.exp_count));
        if (v.st_valid && v.exp_ready && v.st_width != 2'b11)
            push_exp(v.st_addr, v.st_wd, v.st_width);
        finish_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Fill with a load holding the port, then drain in order.
        add(1, 32'h0, 32'h11, 2'b00, 1, FarLd, 1, 0, 0, 0);
        add(1, 32'h4, 32'h22, 2'b00, 1, FarLd, 1, 0, 0, 1);
        add(1, 32'h8, 32'h33, 2'b00, 1, FarLd, 1, 0, 0, 2);
        add(1, 32'hC, 32'h44, 2'b00, 1, FarLd, 1, 0, 0, 3);
        add(1, 32'h50, 32'h99, 2'b00, 1, FarLd, 0, 0, 0, 4);  // full: refused
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 1, 4);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 1, 3);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 1, 2);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 1, 1);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 0, 0);
        // Refill, then push and pop together at full.
        add(1, 32'h0, 32'h11, 2'b00, 1, FarLd, 1, 0, 0, 0);
        add(1, 32'h4, 32'h22, 2'b00, 1, FarLd, 1, 0, 0, 1);
        add(1, 32'h8, 32'h33, 2'b00, 1, FarLd, 1, 0, 0, 2);
        add(1, 32'hC, 32'h44, 2'b00, 1, FarLd, 1, 0, 0, 3);
        add(1, 32'h10, 32'h55, 2'b00, 0, FarLd, 1, 0, 1, 4);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 1, 4);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 1, 3);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 1, 2);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 1, 1);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 0, 0);
        // Invalid width is accepted and dropped.
        add(1, 32'h30, 32'h77, 2'b11, 1, FarLd, 1, 0, 0, 0);
        add(0, 32'h0, 32'h0, 2'b00, 1, 32'h30, 1, 0, 0, 0);
        add(0, 32'h0, 32'h0, 2'b00, 0, FarLd, 1, 0, 0, 0);

        // Reset state.
        reset = 1'b1;
        drive(0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        #2;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_dm_we", 32'(dm_we), 32'd0);
        check("rst_ld_hazard", 32'(ld_hazard), 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        check("sb_empty_after_table", 32'(sb.size()), 32'd0);

        // Byte store at 0x21, then a load to word 0x20 stalls while it drains.
        drive(1, 32'h21, 32'hAB, 2'b10, 1, FarLd);
        push_exp(32'h21, 32'hAB, 2'b10);
        #4;
        check("hz_push_count", 32'(count), 32'd0);
        finish_cycle();
        drive(0, 32'h0, 32'h0, 2'b00, 1, 32'h20);
        #4;
        check("hz_ld_hazard", 32'(ld_hazard), 32'd1);
        check("hz_dm_we", 32'(dm_we), 32'd1);
        check("hz_dm_addr", dm_addr, 32'h21);
        check("hz_dm_width", 32'(dm_width), 32'd2);
        finish_cycle();
        #4;
        check("hz_after_ld_hazard", 32'(ld_hazard), 32'd0);
        check("hz_after_dm_we", 32'(dm_we), 32'd0);
        check("hz_after_dm_addr", dm_addr, 32'h20);
        finish_cycle();

        // Ten push/drain pairs wrap the pointers; data = index.
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h40 + 32'(i) * 4, 32'(i), 2'b00, 0, FarLd);
            push_exp(32'h40 + 32'(i) * 4, 32'(i), 2'b00);
            #4;
            check($sformatf("wrap%0d_count", i), 32'(count), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("wrap%0d_le4", i), 32'(count <= 3'd4), 32'd1);
            finish_cycle();
        end
        drive(0, 32'h0, 32'h0, 2'b00, 0, FarLd);
        #4;
        check("wrap_last_we", 32'(dm_we), 32'd1);
        finish_cycle();
        #4;
        check("wrap_empty", 32'(empty), 32'd1);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);
        finish_cycle();

        // Reset in the middle of a drain discards pending stores.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h80 + 32'(i) * 4, 32'hC0 + 32'(i), 2'b00, 1, FarLd);
            #4;
            finish_cycle();
        end
        drive(0, 32'h0, 32'h0, 2'b00, 0, FarLd);
        #2;
        check("mid_pre_count", 32'(count), 32'd3);
        check("mid_pre_dm_we", 32'(dm_we), 32'd1);
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_dm_we", 32'(dm_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            check($sformatf("post_rst%0d_dm_we", i), 32'(dm_we), 32'd0);
            finish_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
